// File: rtl/bsg_link_loopback_tester_pkg.sv
// Shared types and helpers for the link loopback tester: FSM state encoding,
// Galois LFSR tap masks and the {seq, lfsr} word composition.
package bsg_link_loopback_tester_pkg;

  typedef enum logic [1:0] {eIDLE, eSEND, eDRAIN, eDONE} state_e;

  // Right-shifting Galois masks; bit (t-1) is set for each maximal-length tap t.
  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    case (w)
      3:       return 64'h6;
      4:       return 64'hC;
      5:       return 64'h14;
      6:       return 64'h30;
      7:       return 64'h60;
      8:       return 64'hB8;
      16:      return 64'hD008;
      24:      return 64'hE10000;
      32:      return 64'h8020_0003;
      default: return 64'd1 << (w - 1);
    endcase
  endfunction

  function automatic logic [63:0] compose_word(input int unsigned seq_w,
                                               input int unsigned lfsr_w,
                                               input logic [63:0] seq,
                                               input logic [63:0] lfsr);
    logic [63:0] seq_mask;
    logic [63:0] lfsr_mask;
    seq_mask  = (64'd1 << seq_w) - 64'd1;
    lfsr_mask = (64'd1 << lfsr_w) - 64'd1;
    return ((seq & seq_mask) << lfsr_w) | (lfsr & lfsr_mask);
  endfunction

endpackage

// File: rtl/bsg_link_loopback_tester_if.sv
// One direction of a core-side link channel (data/valid/ready).
// A word moves in every cycle where valid and ready are both high. The master
// keeps valid asserted and data stable until that happens. On the RX channel
// the tester is the slave and its ready is a yumi: it consumes the presented
// word in the same cycle.
interface bsg_link_loopback_tester_if #(parameter int width_p = 32);
  logic [width_p-1:0] data;
  logic               valid;
  logic               ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bsg_link_loopback_tester_lfsr.sv
// Galois LFSR used both as the TX word generator and as the RX expected-value model.
module bsg_link_loopback_tester_lfsr
  import bsg_link_loopback_tester_pkg::*;
#(
  parameter int                 width_p = 24,
  parameter logic [width_p-1:0] seed_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               clear_i,
  output logic [width_p-1:0] q_o
);

  localparam logic [63:0]        taps_full_lp = lfsr_taps(width_p);
  localparam logic [width_p-1:0] taps_lp      = taps_full_lp[width_p-1:0];

  logic [width_p-1:0] lfsr_q, lfsr_d;

  // Clear takes priority so a restart always begins from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (clear_i)   lfsr_d = seed_p;
    else if (en_i) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_lp : '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= seed_p;
    else            lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/bsg_link_loopback_tester.sv
// Link loopback traffic generator/checker: sends N sequence-tagged LFSR words and
// checks them in order on return. Optional BSG_LOOPBACK_TESTER_ERR_INJECT_EN adds inject_i.
module bsg_link_loopback_tester
  import bsg_link_loopback_tester_pkg::*;
#(
  parameter int                             width_p     = 32,
  parameter int                             seq_width_p = 8,
  parameter int                             cnt_width_p = 32,
  parameter logic [width_p-seq_width_p-1:0] seed_p      = 'h1,
  parameter int                             timeout_p   = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic [cnt_width_p-1:0] num_pkts_i,
`ifdef BSG_LOOPBACK_TESTER_ERR_INJECT_EN
  input  logic                   inject_i,
`endif
  bsg_link_loopback_tester_if.master link_tx,
  bsg_link_loopback_tester_if.slave  link_rx,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [cnt_width_p-1:0] err_cnt_o,
  output logic [cnt_width_p-1:0] sent_cnt_o,
  output logic [cnt_width_p-1:0] recv_cnt_o,
  output state_e                 state_o
);

  localparam int                     lfsr_w_lp  = width_p - seq_width_p;
  localparam int                     tmr_w_lp   = $clog2(timeout_p + 1);
  localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);
  localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;
  localparam logic [seq_width_p-1:0] seq_one_lp = seq_width_p'(1);
  localparam logic [tmr_w_lp-1:0]    tmr_one_lp = tmr_w_lp'(1);
  localparam logic [tmr_w_lp-1:0]    tmr_lim_lp = tmr_w_lp'(timeout_p);

  state_e                 state_q, state_d;
  logic [cnt_width_p-1:0] n_q, n_d, sent_q, sent_d, recv_q, recv_d, err_q, err_d;
  logic [seq_width_p-1:0] tx_seq_q, tx_seq_d, rx_seq_q, rx_seq_d;
  logic [tmr_w_lp-1:0]    tmr_q, tmr_d;
  logic                   timeout_q, timeout_d, valid_q, valid_d;

  logic                   lfsr_clear, tx_lfsr_en, rx_lfsr_en;
  logic [lfsr_w_lp-1:0]   tx_lfsr, rx_lfsr;
  logic [width_p-1:0]     tx_word, rx_exp_word;
  logic                   busy, tx_fire, rx_fire, rx_check, rx_err;

  bsg_link_loopback_tester_lfsr #(.width_p(lfsr_w_lp), .seed_p(seed_p)) tx_lfsr_u (
    .clk_i, .reset_n_i, .en_i(tx_lfsr_en), .clear_i(lfsr_clear), .q_o(tx_lfsr)
  );

  bsg_link_loopback_tester_lfsr #(.width_p(lfsr_w_lp), .seed_p(seed_p)) rx_lfsr_u (
    .clk_i, .reset_n_i, .en_i(rx_lfsr_en), .clear_i(lfsr_clear), .q_o(rx_lfsr)
  );

  assign tx_word     = width_p'(compose_word(seq_width_p, lfsr_w_lp, 64'(tx_seq_q), 64'(tx_lfsr)));
  assign rx_exp_word = width_p'(compose_word(seq_width_p, lfsr_w_lp, 64'(rx_seq_q), 64'(rx_lfsr)));

  assign busy     = (state_q == eSEND) || (state_q == eDRAIN);
  assign tx_fire  = valid_q & link_tx.ready;
  assign rx_fire  = link_rx.valid;
  // Only the first N words seen while busy are checked; anything else is a stray.
  assign rx_check = rx_fire & busy & (recv_q != n_q);
  assign rx_err   = rx_fire & (~rx_check | (link_rx.data != rx_exp_word));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    err_d      = err_q;
    tx_seq_d   = tx_seq_q;
    rx_seq_d   = rx_seq_q;
    tmr_d      = tmr_q;
    timeout_d  = timeout_q;
    valid_d    = valid_q;
    lfsr_clear = 1'b0;
    tx_lfsr_en = 1'b0;
    rx_lfsr_en = 1'b0;

    if (rx_check) begin
      recv_d     = recv_q + cnt_one_lp;
      rx_seq_d   = rx_seq_q + seq_one_lp;
      rx_lfsr_en = 1'b1;
    end
    if (rx_err && (err_q != cnt_max_lp)) err_d = err_q + cnt_one_lp;

    case (state_q)
      eIDLE, eDONE: begin
        if (start_i) begin
          n_d        = num_pkts_i;
          sent_d     = '0;
          recv_d     = '0;
          err_d      = '0;
          tx_seq_d   = '0;
          rx_seq_d   = '0;
          tmr_d      = '0;
          timeout_d  = 1'b0;
          lfsr_clear = 1'b1;
          if (num_pkts_i == '0) begin
            state_d = eDONE;
          end else begin
            state_d = eSEND;
            valid_d = 1'b1;
          end
        end
      end
      eSEND: begin
        if (tx_fire) begin
          sent_d     = sent_q + cnt_one_lp;
          tx_seq_d   = tx_seq_q + seq_one_lp;
          tx_lfsr_en = 1'b1;
          if (sent_d == n_q) begin
            state_d = eDRAIN;
            valid_d = 1'b0;
          end
        end
      end
      eDRAIN: begin
        if (recv_q == n_q) begin
          state_d = eDONE;
        end else if (rx_fire) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + tmr_one_lp;
          if (tmr_d == tmr_lim_lp) begin
            timeout_d = 1'b1;
            state_d   = eDONE;
          end
        end
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= eIDLE;
      n_q       <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      err_q     <= '0;
      tx_seq_q  <= '0;
      rx_seq_q  <= '0;
      tmr_q     <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      err_q     <= err_d;
      tx_seq_q  <= tx_seq_d;
      rx_seq_q  <= rx_seq_d;
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
    end
  end

`ifdef BSG_LOOPBACK_TESTER_ERR_INJECT_EN
  // The flip is applied on the outgoing word only; the generator state is untouched.
  assign link_tx.data = tx_word ^ {{(width_p-1){1'b0}}, inject_i & valid_q};
`else
  assign link_tx.data = tx_word;
`endif
  assign link_tx.valid = valid_q;
  assign link_rx.ready = link_rx.valid;

  assign busy_o     = busy;
  assign done_o     = (state_q == eDONE);
  assign pass_o     = (state_q == eDONE) && (err_q == '0) && !timeout_q;
  assign err_cnt_o  = err_q;
  assign sent_cnt_o = sent_q;
  assign recv_cnt_o = recv_q;
  assign state_o    = state_q;

endmodule
